// File: rtl/uart_pkg.sv
// Shared types and frame-length constants for the UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    // Start + stop bits plus the optional parity bit.
    localparam int unsigned OVERHEAD_BITS = 2 + PARITY_BITS;

    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned clks_per_bit);
        return (data_w + OVERHEAD_BITS) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_end = (count == LAST) && !restart;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + DATA_W bits LSB first + stop out.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    uart_tx_state_t    state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              bit_end;
    logic              accept;
`ifdef UART_TX_PARITY_EN
    logic              parity;
`endif

    assign accept = (state == IDLE) && tx_valid && tx_ready && !flush;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .bit_end (bit_end)
    );

    // tx_serial always carries the bit for the state being entered, so the line is a flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (flush) begin
                state     <= IDLE;
                idx       <= '0;
                tx_serial <= 1'b1;
                tx_ready  <= 1'b1;
                tx_busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            shreg     <= tx_data;
`ifdef UART_TX_PARITY_EN
                            parity    <= ^tx_data;
`endif
                            idx       <= '0;
                            tx_serial <= 1'b0;
                            tx_ready  <= 1'b0;
                            tx_busy   <= 1'b1;
                            state     <= START;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            tx_serial <= shreg[0];
                            shreg     <= shreg >> 1;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                                tx_serial <= parity;
                                state     <= PARITY;
`else
                                tx_serial <= 1'b1;
                                state     <= STOP;
`endif
                            end else begin
                                idx       <= idx + 1'b1;
                                tx_serial <= shreg[0];
                                shreg     <= shreg >> 1;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            tx_serial <= 1'b1;
                            state     <= STOP;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
